// File: rtl/mem_port_arbiter.sv
// Arbiter sequencing one fixed-latency unified memory between IF and MEM.
// Data has priority; stalls hold the pipeline until read data is registered.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, DACC, IACC, DDONE, IDONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              en_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d, ird_d, drd_d;
  logic              d_req;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    en_d    = mem_en;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    ird_d   = if_rdata;
    drd_d   = d_rdata;
    unique case (state)
      IDLE: begin
        if (d_req) begin
          state_d = DACC;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_write;
          en_d    = 1'b1;
          cnt_d   = CNT_INIT;
        end else if (if_req) begin
          state_d = IACC;
          addr_d  = if_addr;
          we_d    = 1'b0;
          en_d    = 1'b1;
          cnt_d   = CNT_INIT;
        end
      end
      DACC, IACC: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          en_d = 1'b0;
          we_d = 1'b0;
          if (state == DACC) begin
            state_d = DDONE;
            // read+write together was issued as a write
            if (!mem_we) drd_d = mem_rdata;
          end else begin
            state_d = IDONE;
            ird_d   = mem_rdata;
          end
        end
      end
      DDONE, IDONE: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if_rdata  <= ird_d;
      d_rdata   <= drd_d;
    end
  end

  assign d_stall  = !reset && d_req && (state != DDONE);
  assign if_stall = !reset &&
                    ((if_req && (state != IDONE)) || d_stall);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a
// randomized pipeline-style run checked against a shadow memory.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        if_req, if_stall, d_read, d_write, d_stall;
  logic        mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req1, if_stall1, d_read1, d_write1, d_stall1;
  logic        mem_en1, mem_we1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  int checks = 0;
  int errors = 0;

  logic [31:0] phys   [0:255];
  logic [31:0] shadow [0:255];
  logic        init_mem;

  mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1),
    .if_rdata(if_rdata1), .if_stall(if_stall1),
    .d_read(d_read1), .d_write(d_write1),
    .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 0)  return 32'h0000_0013;
    if (i == 1)  return 32'h0010_0093;
    if (i == 16) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) phys[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      phys[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata  = phys[mem_addr[9:2]];
  assign mem_rdata1 = {mem_addr1[15:0], 16'hF00D};

  task automatic drive_data(
    input  logic rd, input logic wr,
    input  logic [31:0] a, input logic [31:0] w,
    output int st, output int en, output int wen,
    output int bad, output logic [31:0] rdv);
    @(posedge clk); #1;
    d_read = rd; d_write = wr; d_addr = a; d_wdata = w;
    st = 0; en = 0; wen = 0; bad = 0; rdv = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_en) begin
        en++;
        if (mem_we) wen++;
        if (mem_addr !== a || mem_we !== wr ||
            (wr && mem_wdata !== w)) bad++;
      end
      if (!d_stall) begin
        rdv = d_rdata;
        break;
      end
      st++;
    end
    @(posedge clk); #1;
    d_read = 0; d_write = 0;
  endtask

  task automatic test_reset;
    reset = 1; init_mem = 1;
    d_read = 1; if_req = 1;
    repeat (2) @(posedge clk);
    #1 init_mem = 0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, d_stall, if_stall} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0000",
               {mem_en, mem_we, d_stall, if_stall});
    end
    checks++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (d_rdata !== 0 || if_rdata !== 0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h exp 0/0", d_rdata, if_rdata);
    end
    checks++;
    if (mem_en1 !== 0 || d_rdata1 !== 0) begin
      errors++;
      $display("FAIL reset_dut1 got %b/%h exp 0/0", mem_en1, d_rdata1);
    end
    @(posedge clk); #1;
    reset = 0; d_read = 0; if_req = 0;
  endtask

  task automatic test_load;
    int st, en, wen, bad;
    logic [31:0] rdv;
    drive_data(1, 0, 32'h40, 32'h0, st, en, wen, bad, rdv);
    checks++;
    if (st !== 3) begin
      errors++; $display("FAIL load_stall got %0d exp 3", st);
    end
    checks++;
    if (en !== 2 || wen !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL load_en got en=%0d we=%0d bad=%0d exp 2/0/0",
               en, wen, bad);
    end
    checks++;
    if (rdv !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_data got %h exp deadbeef", rdv);
    end
  endtask

  task automatic test_store;
    int st, en, wen, bad;
    logic [31:0] rdv;
    drive_data(0, 1, 32'h80, 32'h1234_5678, st, en, wen, bad, rdv);
    checks++;
    if (st !== 3) begin
      errors++; $display("FAIL store_stall got %0d exp 3", st);
    end
    checks++;
    if (en !== 2 || wen !== 2 || bad !== 0) begin
      errors++;
      $display("FAIL store_en got en=%0d we=%0d bad=%0d exp 2/2/0",
               en, wen, bad);
    end
    checks++;
    if (rdv !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_rdata got %h exp deadbeef", rdv);
    end
    checks++;
    if (phys[32] !== 32'h1234_5678) begin
      errors++; $display("FAIL store_mem got %h exp 12345678", phys[32]);
    end
  endtask

  task automatic test_contention;
    logic [7:0] eds, eis, een;
    logic [31:0] ea;
    eds = 8'b0000_0111;
    eis = 8'b0111_1111;
    een = 8'b0110_0110;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0; d_read = 1; d_addr = 32'h40;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ea = (c < 4) ? 32'h40 : 32'h0;
      checks++;
      if ({d_stall, if_stall, mem_en} !== {eds[c], eis[c], een[c]}) begin
        errors++;
        $display("FAIL contend_ctl c%0d got %b exp %b", c,
                 {d_stall, if_stall, mem_en}, {eds[c], eis[c], een[c]});
      end
      if (een[c]) begin
        checks++;
        if (mem_addr !== ea || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL contend_addr c%0d got %h we%b exp %h we0",
                   c, mem_addr, mem_we, ea);
        end
      end
      if (c == 3) begin
        checks++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL contend_drd got %h exp deadbeef", d_rdata);
        end
      end
      if (c == 7) begin
        checks++;
        if (if_rdata !== 32'h0000_0013) begin
          errors++; $display("FAIL contend_ird got %h exp 00000013", if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) d_read = 0;
    end
    if_req = 0;
  endtask

  task automatic test_data_during_fetch;
    logic [7:0] eds, een;
    logic [31:0] ea;
    eds = 8'b0111_1110;
    een = 8'b0110_0110;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h4;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ea = (c < 3) ? 32'h4 : 32'h84;
      checks++;
      if ({d_stall, if_stall, mem_en} !== {eds[c], 1'b1, een[c]}) begin
        errors++;
        $display("FAIL dfetch_ctl c%0d got %b exp %b", c,
                 {d_stall, if_stall, mem_en}, {eds[c], 1'b1, een[c]});
      end
      if (een[c]) begin
        checks++;
        if (mem_addr !== ea || mem_we !== (c >= 5)) begin
          errors++;
          $display("FAIL dfetch_addr c%0d got %h we%b exp %h",
                   c, mem_addr, mem_we, ea);
        end
      end
      if (c == 3) begin
        checks++;
        if (if_rdata !== 32'h0010_0093) begin
          errors++; $display("FAIL dfetch_ird got %h exp 00100093", if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin
        d_write = 1; d_addr = 32'h84; d_wdata = 32'hA5A5_A5A5;
      end
    end
    if_req = 0; d_write = 0;
  endtask

  task automatic test_lat1;
    int st, en, wen;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      d_read1 = 1; d_write1 = (k == 1);
      d_addr1 = (k == 0) ? 32'h10 : 32'h20;
      d_wdata1 = 32'h77;
      st = 0; en = 0; wen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_en1) begin
          en++;
          if (mem_we1) wen++;
        end
        if (!d_stall1) break;
        st++;
      end
      checks++;
      if (st !== 2 || en !== 1 || wen !== k) begin
        errors++;
        $display("FAIL lat1_k%0d got st=%0d en=%0d we=%0d exp 2/1/%0d",
                 k, st, en, wen, k);
      end
      checks++;
      if (d_rdata1 !== 32'h0010_F00D) begin
        errors++; $display("FAIL lat1_rdata_k%0d got %h exp 0010f00d",
                           k, d_rdata1);
      end
      @(posedge clk); #1;
      d_read1 = 0; d_write1 = 0;
    end
  endtask

  task automatic test_reset_mid_access;
    @(posedge clk); #1;
    d_write = 1; d_addr = 32'h88; d_wdata = 32'hFFFF_0000;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    checks++;
    if (d_stall !== 0 || if_stall !== 0) begin
      errors++; $display("FAIL rstmid_forced got %b%b exp 00",
                         d_stall, if_stall);
    end
    @(posedge clk); #1;
    reset = 0; d_write = 0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, d_stall, if_stall} !== 4'b0 ||
        d_rdata !== 0 || if_rdata !== 0) begin
      errors++;
      $display("FAIL rstmid_state got %b drd=%h ird=%h exp 0000/0/0",
               {mem_en, mem_we, d_stall, if_stall}, d_rdata, if_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 0) begin
        errors++; $display("FAIL rstmid_quiet c%0d got %b exp 0", c, mem_en);
      end
    end
  endtask

  task automatic test_random;
    logic d_act, i_act, drd, dwr, exp_valid;
    logic [7:0] di, ii;
    logic [31:0] dw, exp_drd;
    int dwait, iwait;
    d_act = 0; i_act = 0; exp_valid = 0;
    dwait = 0; iwait = 0; drd = 0; dwr = 0;
    di = 0; ii = 0; dw = 0; exp_drd = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; dwait = 0;
        di  = 8'($urandom_range(64, 255));
        dwr = 1'($urandom_range(0, 1));
        drd = !dwr || ($urandom_range(0, 3) == 0);
        dw  = $urandom;
      end
      if (!i_act && $urandom_range(0, 1) == 0) begin
        i_act = 1; iwait = 0;
        ii = 8'($urandom_range(64, 255));
      end
      d_read  = d_act && drd;
      d_write = d_act && dwr;
      d_addr  = {22'd0, di, 2'b00};
      d_wdata = dw;
      if_req  = i_act;
      if_addr = {22'd0, ii, 2'b00};
      @(negedge clk);
      if (d_act) begin
        if (d_stall && dwait < 50) begin
          dwait++;
        end else begin
          checks++;
          if (dwait > 6) begin
            errors++; $display("FAIL rnd_dwait got %0d exp <=6", dwait);
          end
          if (!dwr) begin
            checks++;
            if (d_rdata !== shadow[di]) begin
              errors++;
              $display("FAIL rnd_load @%h got %h exp %h",
                       d_addr, d_rdata, shadow[di]);
            end
            exp_drd = shadow[di]; exp_valid = 1;
          end else begin
            if (exp_valid) begin
              checks++;
              if (d_rdata !== exp_drd) begin
                errors++;
                $display("FAIL rnd_store_rdata got %h exp %h",
                         d_rdata, exp_drd);
              end
            end
            shadow[di] = dw;
          end
          d_act = 0;
        end
      end
      if (i_act) begin
        if (if_stall && iwait < 100) begin
          iwait++;
        end else begin
          checks++;
          if (iwait >= 100 || if_rdata !== shadow[ii]) begin
            errors++;
            $display("FAIL rnd_fetch @%h got %h exp %h wait %0d",
                     if_addr, if_rdata, shadow[ii], iwait);
          end
          i_act = 0;
        end
      end
    end
    @(posedge clk); #1;
    d_read = 0; d_write = 0; if_req = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    reset = 1; init_mem = 1;
    if_req = 0; if_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0;
    if_req1 = 0; if_addr1 = 0; d_read1 = 0; d_write1 = 0;
    d_addr1 = 0; d_wdata1 = 0;
    test_reset;
    test_load;
    test_store;
    test_contention;
    test_data_during_fetch;
    test_lat1;
    test_reset_mid_access;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port, fixed-latency unified memory shared by the IF stage (instruction fetch) and the MEM stage (driven by the EX/MEM register's MemRead/MemWrite/Address/WriteData).
- Arbitrates between the two requesters and holds each access for the memory's latency.
- Raises stall signals so the pipeline freezes until read data is registered and valid.

Parameters:
- MEM_LATENCY, 2, cycles mem_en must be held per access; legal range 1..15.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request.
- if_addr  input  ADDR_W  fetch address (PC).
- if_rdata  output  32  fetched instruction; registered.
- if_stall  output  1  freeze PC and IF/ID.
- d_read  input  1  MemRead from EX/MEM.
- d_write  input  1  MemWrite from EX/MEM.
- d_addr  input  ADDR_W  Address from EX/MEM.
- d_wdata  input  32  WriteDataOut from EX/MEM.
- d_rdata  output  32  load data to MEM/WB; registered.
- d_stall  output  1  freeze all pipeline registers.
- mem_en  output  1  memory access enable; registered.
- mem_we  output  1  memory write enable; registered.
- mem_addr  output  ADDR_W  memory address; registered.
- mem_wdata  output  32  memory write data; registered.
- mem_rdata  input  32  memory read data; valid at the end of the last mem_en cycle.

Behaviour:
- States: IDLE, DACC, IACC, DDONE, IDONE. Down-counter cnt, 4 bits.
- Reset: state=IDLE; cnt=0; mem_en=mem_we=0; mem_addr=mem_wdata=0; if_rdata=d_rdata=0. Stalls are forced 0 while reset is high. Reset mid-access aborts the access, with no write-back to d_rdata/if_rdata.
- IDLE:
  - Data request present (d_read|d_write): go to DACC. Latch mem_addr=d_addr, mem_wdata=d_wdata, mem_we=d_write, mem_en=1, cnt=MEM_LATENCY-1.
  - Otherwise, if_req present: go to IACC. Latch mem_addr=if_addr, mem_we=0, mem_en=1, cnt=MEM_LATENCY-1.
  - Data has fixed priority over fetch; the MEM stage holds the older instruction.
- DACC/IACC:
  - mem_en, mem_we, mem_addr and mem_wdata are held stable.
  - cnt>0: decrement.
  - cnt==0: clear mem_en and mem_we. Then:
    - DACC goes to DDONE. If the access was a read, capture d_rdata=mem_rdata.
    - IACC goes to IDONE, capturing if_rdata=mem_rdata.
- DDONE/IDONE: one cycle, then unconditionally to IDLE. New requests are evaluated only in IDLE.
- d_stall: 1 when (d_read|d_write) and state is not DDONE. This covers the request cycle in IDLE and all DACC cycles, plus any cycle a data request waits behind IACC/IDONE. It is 0 in DDONE, where the pipeline advances and d_rdata is valid.
- if_stall: 1 when if_req and state is not IDONE. It is also 1 whenever d_stall=1, since fetch is frozen by a data stall.
- Latency:
  - An uncontended data access stalls MEM_LATENCY+1 cycles; the completion cycle is the DDONE cycle.
  - An uncontended fetch behaves the same way with IDONE.
- Read and write asserted together: treated as a write. mem_we=1 and d_rdata is unchanged.
- A write never updates d_rdata. d_rdata and if_rdata hold their value until the next matching completion.
- Request dropped mid-access: the access still completes. Inputs are sampled only in IDLE.
- Back-to-back:
  - A new data request in the cycle after DDONE issues from IDLE.
  - There is exactly one IDLE cycle between accesses.

Test Plan:
- Reset, then an uncontended load: d_read=1, d_addr=0x40, mem returns 0xDEADBEEF, MEM_LATENCY=2. Required: d_stall high for 3 cycles; mem_en high for exactly 2 cycles with mem_addr=0x40; d_rdata=0xDEADBEEF in DDONE with d_stall=0.
- Store: d_write=1, d_addr=0x80, d_wdata=0x12345678. Required: mem_we=mem_en=1 for 2 cycles with mem_wdata=0x12345678; d_rdata unchanged; d_stall low in DDONE.
- Simultaneous if_req (if_addr=0x0) and d_read (0x40) in IDLE. Required: the data access is issued first; if_stall stays high through DACC, DDONE, IDLE and IACC; the fetch of 0x0 is issued after DDONE→IDLE; if_rdata is valid in IDONE.
- Data request arriving during IACC. Required: the fetch completes untouched; d_stall stays high until the following DDONE; mem_addr stays stable during IACC.
- Reset asserted in the second DACC cycle. Required: next cycle state=IDLE, mem_en=0, d_rdata=0, both stalls 0; no memory write is observed after reset.
- MEM_LATENCY=1 with d_read and d_write both high. Required: a single mem_en/mem_we cycle (write), 2 stall cycles, and d_rdata unchanged.
